// File: rtl/sopc_motor_stepgen_if.sv
// ============================================================================
// Module   : sopc_motor_stepgen_if
// Purpose  : Avalon-MM slave bus bundle for the stepper pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sopc_motor_stepgen_if #(
  parameter int AW = 3
) ();
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/sopc_motor_stepgen.sv
// ============================================================================
// Module   : sopc_motor_stepgen
// Purpose  : Multi-channel step/dir pulse generator with Avalon-MM registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sopc_motor_stepgen #(
  parameter int NCH  = 2,
  parameter int SW   = 14,
  parameter int PW   = 16,
  parameter int POSW = 24
) (
  input  wire logic            clk,
  input  wire logic            reset,
  sopc_motor_stepgen_if.slave  bus,
  output logic [NCH-1:0]       step_out,
  output logic [NCH-1:0]       dir_out,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  logic        w_wr;
  logic [31:0] w_ch;
  logic [1:0]  w_reg;
  logic        w_unused;

  logic [NCH-1:0] w_done;
  logic [NCH-1:0] w_irq_en;
  logic [31:0]    w_rd_word [NCH];

  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_ch     = 32'(bus.address >> 2);
  assign w_reg    = bus.address[1:0];
  assign w_unused = &{1'b0, bus.writedata};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t                 r_state, w_state_nxt;
    logic [SW-1:0]          r_steps, r_rem, w_rem_nxt;
    logic [PW-1:0]          r_halfper, r_per, w_per_nxt, r_cnt, w_cnt_nxt;
    logic signed [POSW-1:0] r_pos;
    logic                   r_dir, r_dir_out, r_done, r_irq_en;
    logic                   w_sel, w_ctrl_wr, w_start, w_abort, w_done_clr;
    logic                   w_start_acc, w_done_set, w_pos_step;

    assign w_sel      = w_wr && (w_ch == 32'(i));
    assign w_ctrl_wr  = w_sel && (w_reg == 2'd0);
    assign w_start    = w_ctrl_wr && bus.writedata[0];
    assign w_abort    = w_ctrl_wr && bus.writedata[2];
    assign w_done_clr = w_ctrl_wr && bus.writedata[3];

    always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rem_nxt   = r_rem;
      w_per_nxt   = r_per;
      w_start_acc = 1'b0;
      w_done_set  = 1'b0;
      w_pos_step  = 1'b0;
      if (w_abort) begin
        w_state_nxt = S_IDLE;
        w_done_set  = 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              w_start_acc = 1'b1;
              w_per_nxt   = (r_halfper == '0) ? PW'(1) : r_halfper;
              w_cnt_nxt   = w_per_nxt - PW'(1);
              w_rem_nxt   = r_steps;
              // A zero-length move completes immediately without a pulse.
              if (r_steps == '0) w_done_set  = 1'b1;
              else               w_state_nxt = S_SETUP;
            end
          end
          S_SETUP: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = r_per - PW'(1);
              w_pos_step  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - PW'(1);
            end
          end
          S_HIGH: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_LOW;
              w_cnt_nxt   = r_per - PW'(1);
            end else begin
              w_cnt_nxt = r_cnt - PW'(1);
            end
          end
          default: begin
            if (r_cnt == '0) begin
              w_rem_nxt = r_rem - SW'(1);
              if (r_rem == SW'(1)) begin
                w_state_nxt = S_IDLE;
                w_done_set  = 1'b1;
              end else begin
                w_state_nxt = S_HIGH;
                w_cnt_nxt   = r_per - PW'(1);
                w_pos_step  = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt - PW'(1);
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_steps   <= '0;
        r_halfper <= '0;
        r_rem     <= '0;
        r_per     <= '0;
        r_cnt     <= '0;
        r_pos     <= '0;
        r_dir     <= 1'b0;
        r_dir_out <= 1'b0;
        r_done    <= 1'b0;
        r_irq_en  <= 1'b0;
      end else begin
        r_rem <= w_rem_nxt;
        r_per <= w_per_nxt;
        r_cnt <= w_cnt_nxt;
        if (w_ctrl_wr) begin
          r_dir    <= bus.writedata[1];
          r_irq_en <= bus.writedata[4];
        end
        if (w_sel && w_reg == 2'd1) r_steps   <= bus.writedata[SW-1:0];
        if (w_sel && w_reg == 2'd2) r_halfper <= bus.writedata[PW-1:0];
        if (w_start_acc)            r_dir_out <= bus.writedata[1];
        // Setting done has priority over clearing it.
        if (w_done_set)                     r_done <= 1'b1;
        else if (w_done_clr || w_start_acc) r_done <= 1'b0;
        if (w_sel && w_reg == 2'd3) r_pos <= '0;
        else if (w_pos_step)        r_pos <= r_dir_out ? r_pos - 1'b1 : r_pos + 1'b1;
      end
    end

    always_comb begin
      w_rd_word[i] = '0;
      case (w_reg)
        2'd0:    w_rd_word[i] = {27'd0, r_irq_en, 1'b0, r_done, r_dir, r_state != S_IDLE};
        2'd1:    w_rd_word[i] = 32'(r_steps);
        2'd2:    w_rd_word[i] = 32'(r_halfper);
        default: w_rd_word[i] = 32'($signed(r_pos));
      endcase
    end

    assign step_out[i] = (r_state == S_HIGH);
    assign dir_out[i]  = r_dir_out;
    assign w_done[i]   = r_done;
    assign w_irq_en[i] = r_irq_en;
  end

  assign irq = |(w_done & w_irq_en);

  always_comb begin
    bus.readdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_ch == 32'(i)) bus.readdata = w_rd_word[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sopc_motor_stepgen.sv
// ============================================================================
// Module   : tb_sopc_motor_stepgen
// Purpose  : Directed self-checking bench for the stepper pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sopc_motor_stepgen;

  logic       clk;
  logic       reset;
  logic [1:0] step_out, dir_out;
  logic       irq;
  logic [2:0] step2, dir2;
  logic       irq2;

  int checks   = 0;
  int failures = 0;

  sopc_motor_stepgen_if #(.AW(3)) bif ();
  sopc_motor_stepgen_if #(.AW(4)) bif2 ();

  sopc_motor_stepgen #(.NCH(2), .SW(14), .PW(16), .POSW(24)) dut (
    .clk(clk), .reset(reset), .bus(bif),
    .step_out(step_out), .dir_out(dir_out), .irq(irq)
  );

  // Small instance so the position wrap boundary is reachable quickly.
  sopc_motor_stepgen #(.NCH(3), .SW(8), .PW(4), .POSW(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bif2),
    .step_out(step2), .dir_out(dir2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int d, input int ch, input int rg, input logic [31:0] data);
    if (d == 0) begin
      bif.address = 3'(ch * 4 + rg); bif.chipselect = 1'b1; bif.write_n = 1'b0; bif.writedata = data;
    end else begin
      bif2.address = 4'(ch * 4 + rg); bif2.chipselect = 1'b1; bif2.write_n = 1'b0; bif2.writedata = data;
    end
    @(negedge clk);
    bif.chipselect = 1'b0;  bif.write_n = 1'b1;
    bif2.chipselect = 1'b0; bif2.write_n = 1'b1;
  endtask

  task automatic rchk(input string tag, input int d, input int ch, input int rg, input logic [31:0] exp);
    logic [31:0] v;
    if (d == 0) bif.address = 3'(ch * 4 + rg);
    else        bif2.address = 4'(ch * 4 + rg);
    #1;
    v = (d == 0) ? bif.readdata : bif2.readdata;
    chk(tag, v, exp);
  endtask

  initial begin
    logic [1:0] e;
    reset = 1'b1;
    bif.address = '0;  bif.chipselect = 1'b0;  bif.write_n = 1'b1;  bif.writedata = '0;
    bif2.address = '0; bif2.chipselect = 1'b0; bif2.write_n = 1'b1; bif2.writedata = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rchk("rst_ctrl0", 0, 0, 0, 32'd0);
    rchk("rst_steps0", 0, 0, 1, 32'd0);
    rchk("rst_pos1", 0, 1, 3, 32'd0);

    // ch0: P=3, N=4, forward; done 27 cycles after the start edge
    wr(0, 0, 2, 32'd3);
    wr(0, 0, 1, 32'd4);
    rchk("t1_steps", 0, 0, 1, 32'd4);
    wr(0, 0, 0, 32'h01);
    rchk("t1_busy", 0, 0, 0, 32'h01);
    for (int j = 0; j <= 27; j++) begin
      e = {1'b0, (j >= 3 && j < 27 && ((j - 3) / 3) % 2 == 0)};
      chk($sformatf("t1_step_j%0d", j), 32'(step_out), 32'(e));
      if (j < 27) tick(1);
    end
    rchk("t1_done", 0, 0, 0, 32'h04);
    rchk("t1_pos", 0, 0, 3, 32'd4);
    chk("t1_dir", 32'(dir_out), 32'd0);

    // ch1: HALFPER=0 -> P=1, N=2, reverse, irq enabled
    wr(0, 1, 1, 32'd2);
    wr(0, 1, 0, 32'h13);
    chk("t2_dir", 32'(dir_out), 32'h2);
    for (int j = 0; j <= 5; j++) begin
      e = {(j == 1 || j == 3), 1'b0};
      chk($sformatf("t2_step_j%0d", j), 32'(step_out), 32'(e));
      chk($sformatf("t2_irq_j%0d", j), 32'(irq), 32'(j == 5));
      if (j < 5) tick(1);
    end
    rchk("t2_pos", 0, 1, 3, 32'hFFFF_FFFE);
    rchk("t2_status", 0, 1, 0, 32'h16);
    tick(3);
    chk("t2_irq_hold", 32'(irq), 32'd1);
    wr(0, 1, 0, 32'h18);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    rchk("t2_status_clr", 0, 1, 0, 32'h10);
    chk("t2_dir_hold", 32'(dir_out), 32'h2);

    // ch0: P=5, N=10, abort during third HIGH
    wr(0, 0, 3, 32'hDEAD);
    rchk("t3_pos_clr", 0, 0, 3, 32'd0);
    wr(0, 0, 2, 32'd5);
    wr(0, 0, 1, 32'd10);
    wr(0, 0, 0, 32'h01);
    tick(27);
    chk("t3_high3", 32'(step_out), 32'h1);
    wr(0, 0, 0, 32'h04);
    chk("t3_abort_step", 32'(step_out), 32'd0);
    rchk("t3_status", 0, 0, 0, 32'h04);
    rchk("t3_pos", 0, 0, 3, 32'd3);
    tick(10);
    chk("t3_quiet", 32'(step_out), 32'd0);

    // STEPS=0 start: no pulse, done next cycle
    wr(0, 0, 0, 32'h08);
    rchk("t4_clr", 0, 0, 0, 32'h00);
    wr(0, 0, 1, 32'd0);
    wr(0, 0, 0, 32'h01);
    rchk("t4_zero_done", 0, 0, 0, 32'h04);
    chk("t4_zero_step", 32'(step_out), 32'd0);
    tick(3);
    chk("t4_zero_quiet", 32'(step_out), 32'd0);

    // Start while busy is ignored: P=2, N=2 runs 10 cycles unchanged
    wr(0, 0, 2, 32'd2);
    wr(0, 0, 1, 32'd2);
    wr(0, 0, 0, 32'h01);
    tick(1);
    wr(0, 0, 1, 32'd100);
    wr(0, 0, 0, 32'h01);
    chk("t4_busy_step", 32'(step_out), 32'h1);
    rchk("t4_busy", 0, 0, 0, 32'h01);
    tick(6);
    rchk("t4_busy_j9", 0, 0, 0, 32'h01);
    tick(1);
    rchk("t4_done_j10", 0, 0, 0, 32'h04);
    rchk("t4_pos", 0, 0, 3, 32'd5);
    rchk("t4_steps", 0, 0, 1, 32'd100);

    // Position wrap on the POSW=4 instance: 7 then +1 -> -8
    wr(1, 2, 1, 32'd7);
    wr(1, 2, 0, 32'h01);
    tick(15);
    rchk("t5_pos7", 1, 2, 3, 32'd7);
    rchk("t5_done", 1, 2, 0, 32'h04);
    wr(1, 2, 1, 32'd1);
    wr(1, 2, 0, 32'h01);
    tick(3);
    rchk("t5_wrap", 1, 2, 3, 32'hFFFF_FFF8);
    wr(1, 2, 3, 32'd0);
    rchk("t5_pos_wr", 1, 2, 3, 32'd0);
    wr(1, 3, 1, 32'd5);
    rchk("t5_oor", 1, 3, 1, 32'd0);
    rchk("t5_ch2_steps", 1, 2, 1, 32'd1);
    chk("t5_step2", 32'(step2), 32'd0);

    // Reset mid-pulse on both channels
    wr(0, 0, 2, 32'd2);
    wr(0, 0, 1, 32'd5);
    wr(0, 1, 2, 32'd2);
    wr(0, 1, 1, 32'd5);
    wr(0, 0, 0, 32'h13);
    wr(0, 1, 0, 32'h13);
    tick(2);
    chk("t6_both_high", 32'(step_out), 32'h3);
    chk("t6_both_dir", 32'(dir_out), 32'h3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_step", 32'(step_out), 32'd0);
    chk("t6_dir", 32'(dir_out), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    rchk("t6_ctrl0", 0, 0, 0, 32'd0);
    rchk("t6_steps0", 0, 0, 1, 32'd0);
    rchk("t6_half0", 0, 0, 2, 32'd0);
    rchk("t6_pos0", 0, 0, 3, 32'd0);
    rchk("t6_ctrl1", 0, 1, 0, 32'd0);
    rchk("t6_pos1", 0, 1, 3, 32'd0);
    tick(5);
    chk("t6_quiet", 32'(step_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sopc_motor_stepgen.md
# sopc_motor_stepgen

Parametrised multi-channel stepper-motor pulse generator with an Avalon-MM slave port. It is the next generation of the single-channel 14-bit motor output PIO. Software no longer toggles motor lines directly: per channel it programs a step count, a half-period and a direction. The block then produces step/dir pulses autonomously, tracks a signed position and raises a sticky done flag and an interrupt. It sits in the SOPC system next to the other Avalon slaves and drives the motor driver pins.

## Interface
- NCH, 2: number of independent motor channels (1..8).
- SW, 14: width of the step-count register and remaining-steps counter (1..31).
- PW, 16: width of the half-period register, in clk cycles (1..31).
- POSW, 24: width of the signed position counter (2..32).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  clog2(NCH)+2  word address: bits[1:0] select the register, upper bits select the channel.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states, unused bits 0.
- step_out  out  NCH  step pulse per channel.
- dir_out  out  NCH  direction per channel (0 = forward).
- irq  out  1  OR over channels of (done & irq_en).
- One clock; reset is synchronous and active-high.

## Operation
- Register map per channel; a write occurs when chipselect && !write_n.
- Reg 0, CTRL/STATUS.
  - Write bits: bit0 start, bit1 dir, bit2 abort, bit3 done_clr, bit4 irq_en.
  - Read bits: bit0 busy, bit1 dir, bit2 done, bit4 irq_en.
- Reg 1, STEPS: SW bits, read/write.
- Reg 2, HALFPER: PW bits, read/write. A value of 0 is treated as 1.
- Reg 3, POSITION: signed, sign-extended to 32 bits on read. Any write clears it to 0.
- Out-of-range channel addresses read 0; writes to them are ignored.
- Per-channel FSM:
  - IDLE -> SETUP on start when not busy. On that edge: latch dir into dir_out, load remaining = STEPS and per = max(HALFPER, 1), clear done. If STEPS == 0, go straight to IDLE with done = 1 and emit no pulse.
  - SETUP: step_out low for per cycles (dir setup time), then -> HIGH.
  - HIGH: step_out high for per cycles. On entry, position += 1 (dir 0) or -= 1 (dir 1), wrapping modulo 2^POSW. Then -> LOW.
  - LOW: step_out low for per cycles, then remaining -= 1. If remaining becomes 0 -> IDLE with done = 1; else -> HIGH.
  - Abort (any state): next edge forces IDLE, step_out = 0, done = 1. Remaining steps are discarded and position keeps the count already taken.
- Conflicts and edge cases:
  - Start while busy is ignored.
  - Start and abort in the same write: abort wins.
  - done_clr in the same cycle that done is set: set wins.
  - Writes to STEPS, HALFPER or dir while busy update the register only; they take effect on the next start.
  - dir_out holds its value in IDLE.
- busy = (state != IDLE).

## Timing
- Reset values:
  - All FSMs in IDLE.
  - step_out = 0, dir_out = 0, irq = 0.
  - STEPS = 0, HALFPER = 0, position = 0, done = 0, irq_en = 0.
  - readdata follows the reset register values.
- Start write sampled at edge k: busy = 1 and dir_out valid after edge k. The first step_out rise is after edge k+P, where P = per.
- Each step is P cycles high, then P cycles low. A move of N steps lasts P + 2·N·P cycles from edge k to the edge that sets done.
- irq rises in the same cycle done rises (when irq_en = 1). It falls the cycle after a done_clr write or an irq_en = 0 write.
- Position is readable one cycle after the HIGH entry edge.
- Reset asserted mid-move: on the next edge all outputs return to their reset values with no partial pulse extension.

## Test plan
- NCH=2, ch0 HALFPER=3, STEPS=4, start dir=0 -> step_out[0] low 3 cycles, then 4 pulses of 3 high / 3 low; done after 27 cycles; position=4; ch1 outputs stay 0.
- ch1 STEPS=2, HALFPER=0, start dir=1, irq_en=1 -> per treated as 1; dir_out[1]=1; 2 pulses; position=-2 (read 0xFFFFFFFE); irq=1 until done_clr.
- ch0 STEPS=10, HALFPER=5, start; abort during the 3rd HIGH -> step_out drops on the next edge; busy=0, done=1, position=3.
- STEPS=0 plus start -> no pulse; done=1 on the next cycle. Start write while busy with STEPS=100 -> ignored; the original move completes unchanged.
- Position at 2^23-1 (POSW=24) with one forward step -> wraps to -2^23. A write to reg 3 -> reads 0.
- Reset asserted for 1 cycle mid-pulse on both channels -> step_out, dir_out, irq and all registers are at reset values after that edge.
